// File: rtl/sif_reduce_pkg.sv
// sif_reduce_pkg: shared fp16 width and FSM state encoding for the packet reducer
package sif_reduce_pkg;
  localparam int FP16_W = 16;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, OUT} state_e;
endpackage

// File: rtl/sif_pair_issue.sv
// sif_pair_issue: offers the A and B adder operands once each per addition and
// reports when both have been accepted, in whichever order or cycle they land.
module sif_pair_issue (
  input  logic clk,
  input  logic rst_n,
  input  logic act_i,
  input  logic a_rdy_i,
  input  logic b_rdy_i,
  output logic a_vld_o,
  output logic b_vld_o,
  output logic done_o
);
  logic a_done_q, a_done_d, b_done_q, b_done_d, a_fire, b_fire;
  always_comb begin
    a_vld_o  = act_i & ~a_done_q;
    b_vld_o  = act_i & ~b_done_q;
    a_fire   = a_vld_o & a_rdy_i;
    b_fire   = b_vld_o & b_rdy_i;
    done_o   = act_i & (a_done_q | a_fire) & (b_done_q | b_fire);
    a_done_d = done_o ? 1'b0 : (a_done_q | a_fire);
    b_done_d = done_o ? 1'b0 : (b_done_q | b_fire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
    end
  end
endmodule

// File: rtl/sif_half_fp_reduce.sv
// sif_half_fp_reduce: sums each fp16 X packet through an external adder.
// Define SIF_REDUCE_CNT_EN to add the per-packet element count output R_cnt.
module sif_half_fp_reduce
  import sif_reduce_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              X_vld,
  input  logic [FP16_W-1:0] X_dat,
  input  logic              X_last,
  output logic              X_rdy,
  output logic              ADDA_vld,
  output logic [FP16_W-1:0] ADDA_dat,
  input  logic              ADDA_rdy,
  output logic              ADDB_vld,
  output logic [FP16_W-1:0] ADDB_dat,
  input  logic              ADDB_rdy,
  input  logic              ADDS_vld,
  input  logic [FP16_W-1:0] ADDS_dat,
  output logic              ADDS_rdy,
  output logic              R_vld,
  input  logic              R_rdy,
  output logic [FP16_W-1:0] R_dat
`ifdef SIF_REDUCE_CNT_EN
  ,
  output logic [CNT_W-1:0]  R_cnt
`endif
);
  state_e state_q, state_d;
  logic [FP16_W-1:0] acc_q, acc_d, opb_q, opb_d;
  logic last_q, last_d, x_fire, pair_done;
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  sif_pair_issue u_pair (
    .clk     (clk),
    .rst_n   (rst_n),
    .act_i   (state_q == ISSUE),
    .a_rdy_i (ADDA_rdy),
    .b_rdy_i (ADDB_rdy),
    .a_vld_o (ADDA_vld),
    .b_vld_o (ADDB_vld),
    .done_o  (pair_done)
  );
  assign ADDA_dat = acc_q;
  assign ADDB_dat = opb_q;
  assign R_dat    = acc_q;
  // State resets asynchronously to IDLE, so X_rdy alone needs gating while rst_n is low.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    last_d   = last_q;
    X_rdy    = rst_n & ((state_q == IDLE) | (state_q == FETCH));
    ADDS_rdy = state_q == WAIT;
    R_vld    = state_q == OUT;
    x_fire   = X_vld & X_rdy;
    case (state_q)
      IDLE:  if (x_fire) begin
        acc_d   = X_dat;
        state_d = X_last ? OUT : FETCH;
      end
      FETCH: if (x_fire) begin
        opb_d   = X_dat;
        last_d  = X_last;
        state_d = ISSUE;
      end
      ISSUE: if (pair_done) state_d = WAIT;
      WAIT:  if (ADDS_vld) begin
        acc_d   = ADDS_dat;
        state_d = last_q ? OUT : FETCH;
      end
      OUT:   if (R_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      last_q  <= last_d;
    end
  end
`ifdef SIF_REDUCE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = (state_q == IDLE && x_fire) ? CNT_W'(1) :
            (state_q == FETCH && x_fire && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign R_cnt = cnt_q;
`endif
endmodule
